fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch controller.
// Issues 8-byte aligned fetch-pair requests to the I-cache, at most one
// outstanding. Returned pairs go straight into the instruction buffer.
// An occupancy credit counter stops fetching when the buffer is full.
// A backend squash redirects the fetch PC and flushes the stream. A
// response still in flight when the squash arrives is discarded.
//
// Ports:
//   clock, reset          clock, asynchronous active-high reset
//   squash, squash_pc     backend redirect and its 4-byte aligned target
//   icache_req_*          fetch request handshake (valid/addr/ready)
//   icache_rsp_*          fetch response (valid, 64-bit instruction pair)
//   ib_wr_valid/pc/data   pair written to the instruction buffer
//   ib_pop                consumer dequeued one entry
//   ib_count, ib_full     buffer occupancy credits
module fetch_ctrl #(
    parameter int          IB_DEPTH = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash,
    input  logic [31:0]                 squash_pc,
    output logic                        icache_req_valid,
    output logic [31:0]                 icache_req_addr,
    input  logic                        icache_req_ready,
    input  logic                        icache_rsp_valid,
    input  logic [63:0]                 icache_rsp_data,
    output logic [1:0]                  ib_wr_valid,
    output logic [31:0]                 ib_wr_pc,
    output logic [63:0]                 ib_wr_data,
    input  logic                        ib_pop,
    output logic [$clog2(IB_DEPTH):0]   ib_count,
    output logic                        ib_full
);

    localparam int              CW      = $clog2(IB_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(IB_DEPTH);

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]    state_r, state_s;
    logic [31:0]   pc_r, pc_s;
    logic [31:0]   req_pc_r, req_pc_s;
    logic          req_mis_r, req_mis_s;
    logic [CW-1:0] count_r, count_s;
    logic          req_valid_s;
    logic          wr_en_s;

    // Credit update: a simultaneous write and pop cancel; a pop at zero is ignored.
    function automatic logic [CW-1:0] count_upd(input logic [CW-1:0] c,
                                                input logic          wr,
                                                input logic          pop);
        logic [CW-1:0] r;
        if (wr && pop) begin
            r = c;
        end else if (wr) begin
            r = c + CW'(1);
        end else if (pop && (c != '0)) begin
            r = c - CW'(1);
        end else begin
            r = c;
        end
        return r;
    endfunction

    // Next-state, request and write-enable logic.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        req_pc_s    = req_pc_r;
        req_mis_s   = req_mis_r;
        count_s     = count_r;
        req_valid_s = 1'b0;
        wr_en_s     = 1'b0;
        case (state_r)
            FETCH: begin
                // Waiting in WAIT reserves the credit, so only a free slot matters here.
                req_valid_s = !squash && (count_r < DEPTH_C);
                if (squash) begin
                    pc_s    = squash_pc;
                    count_s = '0;
                end else begin
                    if (req_valid_s && icache_req_ready) begin
                        req_pc_s  = {pc_r[31:3], 3'b000};
                        req_mis_s = pc_r[2];
                        state_s   = WAIT;
                    end else begin
                        state_s   = FETCH;
                    end
                    count_s = count_upd(count_r, 1'b0, ib_pop);
                end
            end
            WAIT: begin
                if (squash) begin
                    // A response arriving with the squash is dropped here;
                    // otherwise it is still in flight and must be discarded later.
                    pc_s    = squash_pc;
                    count_s = '0;
                    state_s = icache_rsp_valid ? FETCH : DISCARD;
                end else if (icache_rsp_valid) begin
                    wr_en_s = 1'b1;
                    pc_s    = req_pc_r + 32'd8;
                    state_s = FETCH;
                    count_s = count_upd(count_r, 1'b1, ib_pop);
                end else begin
                    count_s = count_upd(count_r, 1'b0, ib_pop);
                end
            end
            DISCARD: begin
                if (squash) begin
                    pc_s = squash_pc;
                end else begin
                    pc_s = pc_r;
                end
                // The stale response is the only one outstanding, so leave on it
                // even if a fresh squash arrives in the same cycle.
                if (icache_rsp_valid) begin
                    state_s = FETCH;
                end else begin
                    state_s = DISCARD;
                end
                count_s = count_upd(count_r, 1'b0, ib_pop);
            end
            default: begin
                state_s = FETCH;
                pc_s    = RESET_PC;
                count_s = '0;
            end
        endcase
    end

    // Fetch state, PC, latched request and credit registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= FETCH;
            pc_r      <= RESET_PC;
            req_pc_r  <= 32'h0;
            req_mis_r <= 1'b0;
            count_r   <= '0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            req_pc_r  <= req_pc_s;
            req_mis_r <= req_mis_s;
            count_r   <= count_s;
        end
    end

    // The handshake outputs are same-cycle by protocol; gating with reset
    // clears them immediately, since FETCH at count 0 would otherwise request.
    assign icache_req_valid = req_valid_s && !reset;
    assign icache_req_addr  = {pc_r[31:3], 3'b000};
    // Slot 0 is invalid for the first pair after a redirect to pc[2] = 1.
    assign ib_wr_valid      = (wr_en_s && !reset) ? (req_mis_r ? 2'b10 : 2'b11) : 2'b00;
    assign ib_wr_pc         = req_pc_r;
    assign ib_wr_data       = icache_rsp_data;
    assign ib_count         = count_r;
    assign ib_full          = (count_r == DEPTH_C);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: acts as the I-cache and consumer.
// Expected buffer writes go into a scoreboard queue when the response is
// driven and are compared when the DUT presents the write.
module tb_fetch_ctrl;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        squash;
    logic [31:0] squash_pc;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready;
    logic        icache_rsp_valid;
    logic [63:0] icache_rsp_data;
    logic [1:0]  ib_wr_valid;
    logic [31:0] ib_wr_pc;
    logic [63:0] ib_wr_data;
    logic        ib_pop;
    logic [4:0]  ib_count;
    logic        ib_full;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  v;
        logic [63:0] data;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  check_cnt = 0;
    int  error_cnt = 0;
    int  exp_count = 0;

    fetch_ctrl #(.IB_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock            (clock),
        .reset            (reset),
        .squash           (squash),
        .squash_pc        (squash_pc),
        .icache_req_valid (icache_req_valid),
        .icache_req_addr  (icache_req_addr),
        .icache_req_ready (icache_req_ready),
        .icache_rsp_valid (icache_rsp_valid),
        .icache_rsp_data  (icache_rsp_data),
        .ib_wr_valid      (ib_wr_valid),
        .ib_wr_pc         (ib_wr_pc),
        .ib_wr_data       (ib_wr_data),
        .ib_pop           (ib_pop),
        .ib_count         (ib_count),
        .ib_full          (ib_full)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] data_for(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    // Scoreboard monitor: compare every buffer write against the queue head.
    always @(negedge clock) begin
        #2;
        if (ib_wr_valid != 2'b00) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_write", 64'(ib_wr_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("wr_pc",    64'(ib_wr_pc),    64'(mon_e.pc));
                check_eq("wr_valid", 64'(ib_wr_valid), 64'(mon_e.v));
                check_eq("wr_data",  ib_wr_data,       mon_e.data);
            end
        end
    end

    // Offer ready for one cycle and expect the request to be taken at addr.
    task automatic issue(input logic [31:0] addr);
        @(negedge clock);
        icache_req_ready = 1'b1;
        #1;
        check_eq("req_valid", 64'(icache_req_valid), 64'd1);
        check_eq("req_addr",  64'(icache_req_addr),  64'(addr));
        @(posedge clock);
        #1;
        icache_req_ready = 1'b0;
    endtask

    // Return the pair for addr in the next cycle, optionally popping too.
    task automatic respond(input logic [31:0] addr, input logic [1:0] v, input logic pop);
        wr_t e;
        @(negedge clock);
        e.pc = addr; e.v = v; e.data = data_for(addr);
        sb.push_back(e);
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = data_for(addr);
        ib_pop           = pop;
        @(posedge clock);
        #1;
        icache_rsp_valid = 1'b0;
        ib_pop           = 1'b0;
        if (!pop) exp_count++;
        check_eq("count_after_wr", 64'(ib_count), 64'(exp_count));
    endtask

    task automatic pop_one();
        @(negedge clock);
        ib_pop = 1'b1;
        @(posedge clock);
        #1;
        ib_pop = 1'b0;
        if (exp_count > 0) exp_count--;
        check_eq("count_after_pop", 64'(ib_count), 64'(exp_count));
    endtask

    task automatic squash_fetch(input logic [31:0] target);
        @(negedge clock);
        squash = 1'b1; squash_pc = target; icache_req_ready = 1'b1;
        #1;
        check_eq("squash_no_req", 64'(icache_req_valid), 64'd0);
        @(posedge clock);
        #1;
        squash = 1'b0; icache_req_ready = 1'b0;
        exp_count = 0;
        check_eq("squash_count", 64'(ib_count), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; squash = 1'b0; squash_pc = 32'h0;
        icache_req_ready = 1'b0; icache_rsp_valid = 1'b0;
        icache_rsp_data = 64'h0; ib_pop = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check_eq("rst_req_valid", 64'(icache_req_valid), 64'd0);
        check_eq("rst_wr_valid",  64'(ib_wr_valid),      64'd0);
        check_eq("rst_count",     64'(ib_count),         64'd0);
        check_eq("rst_full",      64'(ib_full),          64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Sequential fill with no pops until the buffer is full.
        for (int i = 0; i < DEPTH; i++) begin
            issue(32'(i * 8));
            respond(32'(i * 8), 2'b11, 1'b0);
        end
        @(negedge clock);
        icache_req_ready = 1'b1;
        #1;
        check_eq("full_flag",    64'(ib_full),          64'd1);
        check_eq("full_no_req",  64'(icache_req_valid), 64'd0);
        @(posedge clock);
        #1;
        icache_req_ready = 1'b0;
        pop_one();
        issue(32'h80);
        respond(32'h80, 2'b11, 1'b0);
        check_eq("refull_flag", 64'(ib_full), 64'd1);

        // Squash in FETCH, then write+pop at count 5 and pop at count 0.
        squash_fetch(32'h200);
        for (int i = 0; i < 5; i++) begin
            issue(32'h200 + 32'(i * 8));
            respond(32'h200 + 32'(i * 8), 2'b11, 1'b0);
        end
        issue(32'h228);
        respond(32'h228, 2'b11, 1'b1);
        for (int i = 0; i < 5; i++) pop_one();
        pop_one();

        // Squash while waiting: response three cycles later is discarded.
        issue(32'h230);
        @(negedge clock);
        squash = 1'b1; squash_pc = 32'h104;
        #1;
        check_eq("wait_squash_no_wr", 64'(ib_wr_valid), 64'd0);
        @(posedge clock);
        #1;
        squash = 1'b0;
        exp_count = 0;
        check_eq("wait_squash_count", 64'(ib_count), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            icache_req_ready = 1'b1;
            #1;
            check_eq("discard_no_req", 64'(icache_req_valid), 64'd0);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        icache_rsp_valid = 1'b1; icache_rsp_data = data_for(32'h230);
        #1;
        check_eq("discard_drop", 64'(ib_wr_valid), 64'd0);
        @(posedge clock);
        #1;
        icache_rsp_valid = 1'b0; icache_req_ready = 1'b0;
        issue(32'h100);
        respond(32'h100, 2'b10, 1'b0);
        issue(32'h108);
        respond(32'h108, 2'b11, 1'b0);

        // Squash coincident with the response.
        issue(32'h110);
        @(negedge clock);
        squash = 1'b1; squash_pc = 32'h30C;
        icache_rsp_valid = 1'b1; icache_rsp_data = data_for(32'h110);
        #1;
        check_eq("coinc_no_wr", 64'(ib_wr_valid), 64'd0);
        @(posedge clock);
        #1;
        squash = 1'b0; icache_rsp_valid = 1'b0;
        exp_count = 0;
        check_eq("coinc_count", 64'(ib_count), 64'd0);
        issue(32'h308);
        respond(32'h308, 2'b10, 1'b0);

        // PC wrap at the top of the address space.
        squash_fetch(32'hFFFF_FFF8);
        issue(32'hFFFF_FFF8);
        respond(32'hFFFF_FFF8, 2'b11, 1'b0);
        issue(32'h0);

        // Asynchronous reset in the middle of WAIT.
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        exp_count = 0;
        check_eq("async_rst_count",     64'(ib_count),         64'd0);
        check_eq("async_rst_req_valid", 64'(icache_req_valid), 64'd0);
        check_eq("async_rst_wr_valid",  64'(ib_wr_valid),      64'd0);
        check_eq("async_rst_full",      64'(ib_full),          64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        icache_rsp_valid = 1'b1; icache_rsp_data = data_for(32'h0);
        #1;
        check_eq("late_rsp_ignored", 64'(ib_wr_valid),      64'd0);
        check_eq("restart_req",      64'(icache_req_valid), 64'd1);
        check_eq("restart_addr",     64'(icache_req_addr),  64'd0);
        @(posedge clock);
        #1;
        icache_rsp_valid = 1'b0;
        issue(32'h0);
        respond(32'h0, 2'b11, 1'b0);

        repeat (2) @(posedge clock);
        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
